// File: rtl/alu_op_sequencer.sv
// Issue/capture stage in front of a combinational ALU: one op in flight, result after SETTLE cycles.
// Latency: SETTLE edges from accept to result valid (0 for illegal opcodes). Backpressure: result held until res_ready.
module alu_op_sequencer #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_signal,
    input  logic [WIDTH-1:0] alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             res_err
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       op_legal;

    assign in_ready = (state == IDLE);

    always_comb begin
        op_legal = 1'b0;
        case (in_op)
            3'b000, 3'b001, 3'b010, 3'b110, 3'b111: op_legal = 1'b1;
            default:                                op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_signal <= '0;
            res_data   <= '0;
            res_valid  <= 1'b0;
            res_zero   <= 1'b0;
            res_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (op_legal) begin
                            alu_a      <= in_a;
                            alu_b      <= in_b;
                            alu_signal <= in_op;
                            cnt        <= 4'(SETTLE - 1);
                            state      <= WAIT;
                        end else begin
                            // Illegal op never reaches the ALU; report straight away.
                            res_data  <= '0;
                            res_zero  <= 1'b1;
                            res_err   <= 1'b1;
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        res_data  <= alu_out;
                        res_zero  <= (alu_out == '0);
                        res_err   <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU on the alu_* bus.
module tb_alu_op_sequencer;

    typedef struct {
        logic [3:0] data;
        logic       zero;
        logic       err;
        int         acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [3:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 4'd1 : 4'd0;
            default: return 4'd0;
        endcase
    endfunction

    // SETTLE=1 instance
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, in_ready, res_ready = 1'b1;
    logic [2:0] in_op = '0, alu_signal;
    logic [3:0] in_a = '0, in_b = '0, alu_a, alu_b, alu_out, res_data;
    logic       res_valid, res_zero, res_err;

    assign alu_out = alu_ref(alu_signal, alu_a, alu_b);

    alu_op_sequencer #(.WIDTH(4), .SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_signal(alu_signal), .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_zero(res_zero), .res_err(res_err)
    );

    // SETTLE=3 instance
    logic       rst3_n = 1'b0;
    logic       v3 = 1'b0, rdy3, rr3 = 1'b1;
    logic [2:0] op3 = '0, sig3;
    logic [3:0] a3 = '0, b3 = '0, alu_a3, alu_b3, alu_out3, data3;
    logic       rv3, zero3, err3;

    assign alu_out3 = alu_ref(sig3, alu_a3, alu_b3);

    alu_op_sequencer #(.WIDTH(4), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst3_n), .in_valid(v3), .in_ready(rdy3),
        .in_op(op3), .in_a(a3), .in_b(b3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_signal(sig3), .alu_out(alu_out3),
        .res_valid(rv3), .res_ready(rr3), .res_data(data3),
        .res_zero(zero3), .res_err(err3)
    );

    exp_t sb[$];
    logic vld_d = 1'b0;

    // Monitor: latency on first valid, content on each handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (res_valid && !vld_d) begin
                if (sb.size() == 0) chk("unexpected_result", 1, 0);
                else chk("latency", cyc, sb[0].acc + (sb[0].err ? 0 : 1));
            end
            if (res_valid && res_ready && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("res_data", res_data, e.data);
                chk("res_zero", res_zero, e.zero);
                chk("res_err",  res_err,  e.err);
            end
            vld_d = res_valid;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] d, input logic err);
        exp_t e;
        int   t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("issue_timeout", 0, 1);
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_b = b;
        e.acc  = cyc + 1;
        e.data = d;
        e.zero = (d == 4'd0);
        e.err  = err;
        @(posedge clk);
        sb.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        logic [2:0] rop;
        logic [3:0] ra, rb;
        int c, t, seen;

        #2;
        chk("rst_outputs", {alu_a, alu_b, alu_signal, res_data, res_valid, res_zero, res_err}, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        rst3_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);

        // 1: and
        issue(3'b000, 4'b0011, 4'b1101, 4'b0001, 1'b0);
        chk("t1_alu_signal", alu_signal, 3'b000);
        chk("t1_alu_ab", {alu_a, alu_b}, 8'b0011_1101);
        // 2: add wrap
        issue(3'b010, 4'b1000, 4'b1111, 4'b0111, 1'b0);
        issue(3'b010, 4'b0010, 4'b1100, 4'b1110, 1'b0);
        // 3: sub, slt, and, or-zero
        issue(3'b110, 4'b1011, 4'b0010, 4'b1001, 1'b0);
        issue(3'b111, 4'b0010, 4'b0101, 4'b0001, 1'b0);
        issue(3'b000, 4'b0110, 4'b0100, 4'b0100, 1'b0);
        issue(3'b001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        drain();
        // 4: illegal opcode leaves the ALU drive untouched
        issue(3'b100, 4'b1111, 4'b1111, 4'b0000, 1'b1);
        chk("t4_alu_signal_held", {alu_signal, alu_a, alu_b}, {3'b001, 4'b0000, 4'b0000});
        drain();
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 4))
                0: rop = 3'b000;
                1: rop = 3'b001;
                2: rop = 3'b010;
                3: rop = 3'b110;
                default: rop = 3'b111;
            endcase
            ra = 4'($urandom);
            rb = 4'($urandom);
            issue(rop, ra, rb, alu_ref(rop, ra, rb), 1'b0);
        end
        drain();

        // 5: backpressure with ignored in_valid pulses
        @(negedge clk);
        res_ready = 1'b0;
        issue(3'b000, 4'b0110, 4'b1100, 4'b0100, 1'b0);
        t = 0;
        while (!res_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("t5_valid_seen", res_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_hold", {res_valid, res_data, in_ready}, {1'b1, 4'b0100, 1'b0});
            in_valid = (i % 2 == 0);
            in_op = 3'b010;
            in_a = 4'd1;
            in_b = 4'd1;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t5_idle", {in_ready, res_valid}, 2'b10);
        drain();

        // 6: SETTLE=3 capture timing
        @(negedge clk);
        c = cyc;
        v3 = 1'b1;
        op3 = 3'b010;
        a3 = 4'd5;
        b3 = 4'd6;
        @(posedge clk);
        #1 v3 = 1'b0;
        t = 0;
        @(negedge clk);
        while (!rv3 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("s3_latency", cyc, c + 4);
        chk("s3_data", {data3, zero3, err3}, {4'b1011, 1'b0, 1'b0});
        @(negedge clk);
        chk("s3_released", rv3, 0);

        // reset during WAIT drops the op
        @(negedge clk);
        v3 = 1'b1;
        op3 = 3'b110;
        a3 = 4'd9;
        b3 = 4'd2;
        @(posedge clk);
        #1 v3 = 1'b0;
        #2 rst3_n = 1'b0;
        #1;
        chk("s3_rst_outputs", {alu_a3, alu_b3, sig3, data3, rv3, zero3, err3}, 0);
        @(negedge clk);
        rst3_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rv3) seen++;
        end
        chk("s3_no_result_after_rst", seen, 0);
        chk("s3_ready_after_rst", rdy3, 1);

        chk("sb_empty_end", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
